// File: rtl/cmp_sweep_if.sv
// Operand/result bus between the sweep driver (master) and the 4-bit comparison unit (slave).
// The unit's result is a combinational function of x, y and sel.
interface cmp_sweep_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [1:0]       sel;
  logic [7:0]       cmp;

  modport master (output x, output y, output sel, input cmp);
  modport slave  (input x, input y, input sel, output cmp);
endinterface

// File: rtl/cmp_sweep_driver.sv
// Self-test sweep engine: drives every (x, y) operand pair for one latched function code into
// the comparison unit and accumulates a non-zero hit count and the sum of its results.
module cmp_sweep_driver #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  cmp_sweep_if.master          cmp_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH:0]     count_o,
  output logic [2*WIDTH+7:0]   acc_o
);

  localparam int unsigned CntW = 2 * WIDTH + 1;
  localparam int unsigned AccW = 2 * WIDTH + 8;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SetW-1:0]  SetLast = SetW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] OpMax   = '1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic [1:0]        sel_q;
  logic [SetW-1:0]   set_q;
  logic [CntW-1:0]   count_q;
  logic [AccW-1:0]   acc_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      set_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Without a Start everything holds so the last results stay readable.
          if (start_i) begin
            sel_q   <= mode_i;
            x_q     <= '0;
            y_q     <= '0;
            set_q   <= '0;
            count_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (set_q == SetLast) begin
            acc_q   <= acc_q + AccW'(cmp_if.cmp);
            count_q <= count_q + CntW'(cmp_if.cmp != 8'd0);
            set_q   <= '0;
            // The final pair leaves the operands parked at all-ones.
            if (x_q == OpMax && y_q == OpMax) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else if (y_q == OpMax) begin
              y_q <= '0;
              x_q <= x_q + 1'b1;
            end else begin
              y_q <= y_q + 1'b1;
            end
          end else begin
            set_q <= set_q + 1'b1;
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmp_if.x   = x_q;
  assign cmp_if.y   = y_q;
  assign cmp_if.sel = sel_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count_q;
  assign acc_o      = acc_q;

endmodule

// File: tb/tb_cmp_sweep_driver.sv
// Bench for cmp_sweep_driver: an ideal comparison unit on DUT a (SETTLE=1) and a slow unit whose
// result is invalid for 2 cycles after each operand change on DUT b (SETTLE=3).
module tb_cmp_sweep_driver;

  typedef struct {
    logic [8:0]  count;
    logic [15:0] acc;
    logic [1:0]  sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  mode_a = 2'd0, mode_b = 2'd0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [8:0]  count_a, count_b;
  logic [15:0] acc_a, acc_b;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t       sb_q[$];
  logic [7:0] pair_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] cmp_model(input logic [3:0] x, input logic [3:0] y,
                                           input logic [1:0] sel);
    logic [7:0] r;
    case (sel)
      2'b00:   r = (x == y) ? 8'd1 : 8'd0;
      2'b01:   r = (x > y) ? 8'd1 : 8'd0;
      2'b10:   r = (x < y) ? 8'd1 : 8'd0;
      default: r = {4'd0, (x > y) ? x : y};
    endcase
    return r;
  endfunction

  function automatic exp_t expect_sweep(input logic [1:0] m);
    exp_t       e;
    logic [7:0] r;
    e.count = '0;
    e.acc   = '0;
    e.sel   = m;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        r = cmp_model(4'(x), 4'(y), m);
        e.acc = e.acc + 16'(r);
        if (r != 8'd0) e.count = e.count + 9'd1;
      end
    end
    return e;
  endfunction

  cmp_sweep_if #(.WIDTH(4)) ifa ();
  cmp_sweep_if #(.WIDTH(4)) ifb ();

  assign ifa.cmp = cmp_model(ifa.x, ifa.y, ifa.sel);

  // Slow unit: garbage (0xFF) until the operands have been stable for 2 cycles.
  logic [9:0] last_b = '0;
  int         age_b = 0;
  always_ff @(posedge clk) begin
    if ({ifb.x, ifb.y, ifb.sel} != last_b) begin
      last_b <= {ifb.x, ifb.y, ifb.sel};
      age_b  <= 0;
    end else if (age_b < 2) begin
      age_b <= age_b + 1;
    end
  end
  assign ifb.cmp = ({ifb.x, ifb.y, ifb.sel} == last_b && age_b >= 1) ?
                   cmp_model(ifb.x, ifb.y, ifb.sel) : 8'hFF;

  cmp_sweep_driver #(.WIDTH(4), .SETTLE(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .mode_i(mode_a), .cmp_if(ifa.master),
    .busy_o(busy_a), .done_o(done_a), .count_o(count_a), .acc_o(acc_a)
  );

  cmp_sweep_driver #(.WIDTH(4), .SETTLE(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .mode_i(mode_b), .cmp_if(ifb.master),
    .busy_o(busy_b), .done_o(done_b), .count_o(count_b), .acc_o(acc_b)
  );

  task automatic pulse_start(input bit b, input logic [1:0] m);
    @(negedge clk);
    if (b) begin start_b = 1'b1; mode_b = m; end
    else   begin start_a = 1'b1; mode_a = m; end
    @(negedge clk);
    if (b) start_b = 1'b0;
    else   start_a = 1'b0;
  endtask

  // Counts busy cycles until Done is seen; returns at the negedge where Done is high.
  task automatic wait_done(input bit b, output int busy_n, output bit to);
    busy_n = 0;
    to = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (b ? done_b : done_a) begin
        to = 1'b0;
        return;
      end
      if (b ? busy_b : busy_a) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy_a, done_a} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 00", {busy_a, done_a});
    end
    tests_run++;
    if ({count_a, acc_a} !== 25'd0) begin
      tests_failed++; $display("FAIL reset_results: got %h/%h want 0/0", count_a, acc_a);
    end
    tests_run++;
    if ({ifa.x, ifa.y, ifa.sel} !== 10'd0) begin
      tests_failed++; $display("FAIL reset_operands: got %h %h %h want 0", ifa.x, ifa.y, ifa.sel);
    end
    tests_run++;
    if ({busy_b, done_b, count_b, acc_b} !== 27'd0) begin
      tests_failed++; $display("FAIL reset_b: got %b %b %h %h want 0", busy_b, done_b, count_b, acc_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_equal;
    int   bn;
    bit   to;
    exp_t e;
    sb_q.push_back(expect_sweep(2'b00));
    pulse_start(1'b0, 2'b00);
    wait_done(1'b0, bn, to);
    e = sb_q.pop_front();
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL equal_timeout: no Done within bound"); end
    tests_run++;
    if (bn != 256) begin tests_failed++; $display("FAIL equal_busy_len: got %0d want 256", bn); end
    tests_run++;
    if (count_a !== e.count || acc_a !== e.acc) begin
      tests_failed++;
      $display("FAIL equal_result: got %0d/%0d want %0d/%0d", count_a, acc_a, e.count, e.acc);
    end
    tests_run++;
    if ({ifa.x, ifa.y, ifa.sel} !== {4'd15, 4'd15, e.sel}) begin
      tests_failed++;
      $display("FAIL equal_final_ops: got %0d %0d %b want 15 15 %b", ifa.x, ifa.y, ifa.sel, e.sel);
    end
    @(negedge clk);
    tests_run++;
    if ({done_a, busy_a} !== 2'b00) begin
      tests_failed++; $display("FAIL equal_done_pulse: done/busy got %b want 00", {done_a, busy_a});
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (count_a !== e.count || acc_a !== e.acc || ifa.x !== 4'd15) begin
      tests_failed++; $display("FAIL equal_hold: got %0d/%0d x=%0d", count_a, acc_a, ifa.x);
    end
  endtask

  task automatic test_back_to_back;
    int   bn;
    bit   to;
    exp_t e;
    sb_q.push_back(expect_sweep(2'b01));
    sb_q.push_back(expect_sweep(2'b10));
    @(negedge clk);
    start_a = 1'b1;
    mode_a  = 2'b01;
    repeat (20) @(negedge clk);
    mode_a = 2'b10;  // Start stays high: the next sweep should start only from IDLE
    repeat (5) @(negedge clk);
    tests_run++;
    if (ifa.sel !== 2'b01) begin
      tests_failed++; $display("FAIL b2b_mode_in_run: sel got %b want 01", ifa.sel);
    end
    wait_done(1'b0, bn, to);
    e = sb_q.pop_front();
    tests_run++;
    if (to || count_a !== e.count || acc_a !== e.acc || ifa.sel !== e.sel) begin
      tests_failed++;
      $display("FAIL b2b_greater: got %0d/%0d sel %b want %0d/%0d sel %b (to=%0d)",
               count_a, acc_a, ifa.sel, e.count, e.acc, e.sel, to);
    end
    @(negedge clk);
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_start_in_fin: busy got %b want 0", busy_a);
    end
    @(negedge clk);
    tests_run++;
    if (busy_a !== 1'b1 || ifa.sel !== 2'b10 || count_a !== 9'd0) begin
      tests_failed++;
      $display("FAIL b2b_second_start: busy %b sel %b count %0d want 1 10 0", busy_a, ifa.sel, count_a);
    end
    start_a = 1'b0;
    wait_done(1'b0, bn, to);
    e = sb_q.pop_front();
    tests_run++;
    if (to || bn != 256 || count_a !== e.count || acc_a !== e.acc) begin
      tests_failed++;
      $display("FAIL b2b_less: got %0d/%0d busy %0d want %0d/%0d busy 256", count_a, acc_a, bn,
               e.count, e.acc);
    end
  endtask

  task automatic test_max;
    int         bn;
    bit         to;
    exp_t       e;
    logic [7:0] p;
    sb_q.push_back(expect_sweep(2'b11));
    for (int i = 0; i < 256; i++) pair_q.push_back(8'(i));
    pulse_start(1'b0, 2'b11);
    for (int i = 0; i < 256; i++) begin
      p = pair_q.pop_front();
      tests_run++;
      if ({ifa.x, ifa.y} !== p) begin
        tests_failed++;
        $display("FAIL max_order[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ifa.x, ifa.y, p[7:4], p[3:0]);
      end
      if (i < 255) @(negedge clk);
    end
    wait_done(1'b0, bn, to);
    e = sb_q.pop_front();
    tests_run++;
    if (to || count_a !== e.count || acc_a !== e.acc) begin
      tests_failed++;
      $display("FAIL max_result: got %0d/%0d want %0d/%0d", count_a, acc_a, e.count, e.acc);
    end
    tests_run++;
    if (count_a !== 9'd255 || acc_a !== 16'd2600) begin
      tests_failed++; $display("FAIL max_const: got %0d/%0d want 255/2600", count_a, acc_a);
    end
  endtask

  task automatic test_settle3;
    int   bn;
    bit   to;
    exp_t e;
    sb_q.push_back(expect_sweep(2'b00));
    pulse_start(1'b1, 2'b00);
    wait_done(1'b1, bn, to);
    e = sb_q.pop_front();
    tests_run++;
    if (to || bn != 768) begin
      tests_failed++; $display("FAIL settle3_busy_len: got %0d want 768 (to=%0d)", bn, to);
    end
    tests_run++;
    if (count_b !== e.count || acc_b !== e.acc) begin
      tests_failed++;
      $display("FAIL settle3_result: got %0d/%0d want %0d/%0d", count_b, acc_b, e.count, e.acc);
    end
    tests_run++;
    if ({ifb.x, ifb.y} !== 8'hFF) begin
      tests_failed++; $display("FAIL settle3_final_ops: got %0d %0d want 15 15", ifb.x, ifb.y);
    end
  endtask

  task automatic test_mid_reset;
    int seen_busy = 0;
    int seen_done = 0;
    pulse_start(1'b0, 2'b01);
    start_a = 1'b1;
    mode_a  = 2'b11;
    repeat (121) @(negedge clk);
    tests_run++;
    if ({ifa.x, ifa.y, ifa.sel} !== {4'd7, 4'd9, 2'b01}) begin
      tests_failed++;
      $display("FAIL midrst_position: got (%0d,%0d) sel %b want (7,9) sel 01", ifa.x, ifa.y, ifa.sel);
    end
    start_a = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy_a, done_a, count_a, acc_a} !== 27'd0) begin
      tests_failed++;
      $display("FAIL midrst_async_results: got %b %b %h %h want 0", busy_a, done_a, count_a, acc_a);
    end
    tests_run++;
    if ({ifa.x, ifa.y, ifa.sel} !== 10'd0) begin
      tests_failed++; $display("FAIL midrst_async_ops: got %0d %0d %b want 0", ifa.x, ifa.y, ifa.sel);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy_a) seen_busy++;
      if (done_a) seen_done++;
    end
    tests_run++;
    if (seen_busy != 0 || seen_done != 0) begin
      tests_failed++;
      $display("FAIL midrst_no_resume: busy %0d done %0d cycles want 0 0", seen_busy, seen_done);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_back_to_back();
    test_max();
    test_settle3();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
